exe_stage_unit: RTL

- Execute-stage consumer of the ID/EXE pipeline register outputs (ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg, eqa, eqb, eimm32).
- Performs single-cycle ALU operations and iterative 32-cycle multiply/divide.
- Registers results and control into the EXE/MEM boundary.
- Drives a stall back to the IF, ID and ID/EXE registers while a multicycle operation is in flight.

---
 rtl/exe_stage_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/exe_stage_unit.sv
// exe_stage_unit: execute stage with single-cycle ALU and iterative 32-cycle multiply/divide
module exe_stage_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ewreg,
  input  logic            em2reg,
  input  logic            ewmem,
  input  logic            ealuimm,
  input  logic [3:0]      ealuc,
  input  logic [4:0]      edestReg,
  input  logic [XLEN-1:0] eqa,
  input  logic [XLEN-1:0] eqb,
  input  logic [XLEN-1:0] eimm32,
  output logic            stall,
  output logic            mwreg,
  output logic            mm2reg,
  output logic            mwmem,
  output logic [4:0]      mdestReg,
  output logic [XLEN-1:0] malu,
  output logic [XLEN-1:0] mqb
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0] op_q;
  logic [XLEN-1:0] a_q, b_q, acc_q;
  logic [XLEN-1:0] b, alu, res;
  logic [XLEN:0] r, diff;
  logic [CW-1:0] sh;
  logic is_mc, ge, load;
  logic mwreg_q, mm2reg_q, mwmem_q;
  logic [4:0] mdest_q;
  logic [XLEN-1:0] malu_q, mqb_q;
  assign b = ealuimm ? eimm32 : eqb;
  assign sh = b[CW-1:0];
  assign is_mc = ewreg && (ealuc == 4'hC || ealuc == 4'hD || ealuc == 4'hE);
  // restoring-division step: shift next dividend bit into the partial remainder and try the subtract
  assign r = {acc_q, a_q[XLEN-1]};
  assign diff = r - {1'b0, b_q};
  assign ge = r >= {1'b0, b_q};
  // single-cycle ALU; multicycle codes reaching here (ewreg=0) and the reserved code yield 0
  always_comb begin
    alu = '0;
    case (ealuc)
      4'h0: alu = eqa + b;
      4'h1: alu = eqa - b;
      4'h2: alu = eqa & b;
      4'h3: alu = eqa | b;
      4'h4: alu = eqa ^ b;
      4'h5: alu = eqa << sh;
      4'h6: alu = eqa >> sh;
      4'h7: alu = $unsigned($signed(eqa) >>> sh);
      4'h8: alu = {{(XLEN-1){1'b0}}, $signed(eqa) < $signed(b)};
      4'h9: alu = {{(XLEN-1){1'b0}}, eqa < b};
      4'hA: alu = b << 16;
      4'hB: alu = ~(eqa | b);
      default: alu = '0;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = is_mc ? BUSY : IDLE;
      BUSY: state_d = (cnt_q == CW'(XLEN-1)) ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  // stall output; held low during reset even if a multicycle op is presented
  always_comb begin
    stall = !rst && ((state_q == IDLE && is_mc) || state_q == BUSY);
  end
  // operand capture and one multiply/divide iteration per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      op_q <= '0;
    end else if (state_q == IDLE && is_mc) begin
      a_q <= eqa;
      b_q <= b;
      acc_q <= '0;
      cnt_q <= '0;
      op_q <= ealuc;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 1'b1;
      if (op_q == 4'hC) begin
        acc_q <= acc_q + (b_q[0] ? a_q : '0);
        a_q <= a_q << 1;
        b_q <= b_q >> 1;
      end else begin
        acc_q <= ge ? diff[XLEN-1:0] : r[XLEN-1:0];
        a_q <= {a_q[XLEN-2:0], ge};
      end
    end
  end
  // m* load real values in plain IDLE and DONE, a bubble otherwise
  assign load = (state_q == IDLE && !is_mc) || state_q == DONE;
  assign res = state_q == DONE ? (op_q == 4'hD ? a_q : acc_q) : alu;
  // EXE/MEM boundary registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mwreg_q <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q <= 1'b0;
      mdest_q <= '0;
      malu_q <= '0;
      mqb_q <= '0;
    end else begin
      mwreg_q <= load && ewreg;
      mm2reg_q <= load && em2reg;
      mwmem_q <= load && ewmem;
      mdest_q <= load ? edestReg : '0;
      malu_q <= load ? res : '0;
      mqb_q <= load ? eqb : '0;
    end
  end
  assign mwreg = mwreg_q;
  assign mm2reg = mm2reg_q;
  assign mwmem = mwmem_q;
  assign mdestReg = mdest_q;
  assign malu = malu_q;
  assign mqb = mqb_q;
endmodule
